// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
// Holds the handshake FSM state encoding and the channel slice helper.
`ifndef XLEN
`define XLEN 32
`endif

`ifndef RISCV_CH
`define RISCV_CH(k, dw) ((k)*(dw)) +: (dw)
`endif

package riscv_pipe_pkg;

  typedef logic [1:0] pipe_state_t;

  localparam pipe_state_t EMPTY = 2'b00;
  localparam pipe_state_t BUSY  = 2'b01;
  localparam pipe_state_t FULL  = 2'b10;

endpackage

// File: rtl/riscv_pipe_data_slot.sv
// Wide data register with async reset, sync init and load enable.
// Init wins over load so a flush can scrub the slot in one cycle.
module riscv_pipe_data_slot #(
  parameter int            W    = 32,
  parameter logic [W-1:0]  INIT = '0
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_load,
  input  logic         i_init,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_data <= INIT;
    end else if (i_init) begin
      o_data <= INIT;
    end else if (i_load) begin
      o_data <= i_data;
    end
  end

endmodule

// File: rtl/riscv_pipeline_stage_reg.sv
// Valid/ready pipeline stage register with a skid slot and sync flush.
// o_ready is decoded from the state register only, never from i_ready.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_pipeline_stage_reg
  import riscv_pipe_pkg::*;
#(
  parameter int            NCH           = 20,
  parameter int            DW            = `XLEN,
  parameter logic [DW-1:0] REGISTER_INIT = '0,
  parameter bit            CLR_DATA      = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_clr,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [NCH*DW-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [NCH*DW-1:0] o_data
);

  localparam int           W      = NCH * DW;
  localparam logic [W-1:0] INIT_W = {NCH{REGISTER_INIT}};

  pipe_state_t  state;
  pipe_state_t  state_nxt;
  logic         in_fire;
  logic         out_fire;
  logic         main_load;
  logic         skid_load;
  logic         slot_init;
  logic [W-1:0] main_d;
  logic [W-1:0] skid_q;

  assign in_fire   = i_valid & o_ready;
  assign out_fire  = o_valid & i_ready;
  assign slot_init = i_clr & CLR_DATA;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (i_clr) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) state_nxt = BUSY;
        end
        BUSY: begin
          if (in_fire && !out_fire) begin
            state_nxt = FULL;
          end else if (!in_fire && out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) state_nxt = BUSY;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    o_valid   = (state != EMPTY);
    o_ready   = (state != FULL);
    main_load = 1'b0;
    skid_load = 1'b0;
    if (!i_clr) begin
      unique case (1'b1)
        (state == EMPTY): main_load = in_fire;
        (state == BUSY): begin
          main_load = in_fire & out_fire;
          skid_load = in_fire & ~out_fire;
        end
        (state == FULL): main_load = out_fire;
        default: ;
      endcase
    end
  end

  // Draining FULL promotes the skid entry; otherwise main takes upstream.
  assign main_d = (state == FULL) ? skid_q : i_data;

  riscv_pipe_data_slot #(
    .W    (W),
    .INIT (INIT_W)
  ) u_main (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_load (main_load),
    .i_init (slot_init),
    .i_data (main_d),
    .o_data (o_data)
  );

  riscv_pipe_data_slot #(
    .W    (W),
    .INIT (INIT_W)
  ) u_skid (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_load (skid_load),
    .i_init (slot_init),
    .i_data (i_data),
    .o_data (skid_q)
  );

endmodule

// File: tb/tb_riscv_pipeline_stage_reg.sv
// Bench for riscv_pipeline_stage_reg: directed cases plus a
// randomized run against a queue model of the stage.
`ifndef RISCV_CH
`define RISCV_CH(k, dw) ((k)*(dw)) +: (dw)
`endif

module tb_riscv_pipeline_stage_reg;

  localparam logic [31:0] INIT_A = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic         a_clr = 1'b0;
  logic         a_vin = 1'b0;
  logic         a_rdy = 1'b0;
  logic [127:0] a_din = '0;
  logic         a_vout;
  logic         a_rout;
  logic [127:0] a_dout;

  logic         b_clr = 1'b0;
  logic         b_vin = 1'b0;
  logic         b_rdy = 1'b0;
  logic [63:0]  b_din = '0;
  logic         b_vout;
  logic         b_rout;
  logic [63:0]  b_dout;

  riscv_pipeline_stage_reg #(
    .NCH           (4),
    .DW            (32),
    .REGISTER_INIT (INIT_A),
    .CLR_DATA      (1'b1)
  ) u_dut_a (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_clr   (a_clr),
    .i_valid (a_vin),
    .o_ready (a_rout),
    .i_data  (a_din),
    .o_valid (a_vout),
    .i_ready (a_rdy),
    .o_data  (a_dout)
  );

  riscv_pipeline_stage_reg #(
    .NCH           (4),
    .DW            (16),
    .REGISTER_INIT (16'h0000),
    .CLR_DATA      (1'b0)
  ) u_dut_b (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_clr   (b_clr),
    .i_valid (b_vin),
    .o_ready (b_rout),
    .i_data  (b_din),
    .o_valid (b_vout),
    .i_ready (b_rdy),
    .o_data  (b_dout)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Push lo then lo+1 with downstream stalled, leaving the stage FULL.
  task automatic fill_a(input logic [31:0] lo);
    a_rdy = 1'b0;
    a_vin = 1'b1;
    a_din = 128'(lo);
    tick;
    chk("fill_valid", 128'(a_vout), 128'(1));
    a_din = 128'(lo + 32'd1);
    tick;
    chk("fill_ready", 128'(a_rout), 128'(0));
    chk("fill_head", a_dout, 128'(lo));
    a_vin = 1'b0;
  endtask

  logic [63:0] q[$];
  logic [63:0] last;
  bit          stall;
  bit          in_f;
  bit          out_f;

  initial begin
    rstn  = 1'b0;
    a_vin = 1'b1;
    a_din = {4{32'h1234_5678}};
    b_vin = 1'b1;
    b_din = {4{16'h5A5A}};
    tick;
    tick;
    chk("rst_a_valid", 128'(a_vout), 128'(0));
    chk("rst_a_ready", 128'(a_rout), 128'(1));
    chk("rst_a_ch3", 128'(a_dout[`RISCV_CH(3, 32)]), 128'(INIT_A));
    chk("rst_a_all", a_dout, {4{INIT_A}});
    chk("rst_b_valid", 128'(b_vout), 128'(0));
    chk("rst_b_ready", 128'(b_rout), 128'(1));
    chk("rst_b_ch3", 128'(b_dout[`RISCV_CH(3, 16)]), 128'(0));
    b_vin = 1'b0;
    a_vin = 1'b0;
    rstn  = 1'b1;
    tick;

    for (int i = 1; i <= 4; i++) begin
      a_vin = 1'b1;
      a_rdy = 1'b1;
      a_din = 128'(i);
      tick;
      chk("stream_valid", 128'(a_vout), 128'(1));
      chk("stream_ch0", 128'(a_dout[`RISCV_CH(0, 32)]), 128'(i));
    end
    a_vin = 1'b0;
    tick;
    chk("stream_drain", 128'(a_vout), 128'(0));

    fill_a(32'h10);
    a_rdy = 1'b1;
    tick;
    chk("skid_second", a_dout, 128'(32'h11));
    chk("skid_ready", 128'(a_rout), 128'(1));
    chk("skid_valid", 128'(a_vout), 128'(1));
    tick;
    chk("skid_empty", 128'(a_vout), 128'(0));

    fill_a(32'h20);
    a_clr = 1'b1;
    a_vin = 1'b1;
    a_din = 128'(32'h55);
    tick;
    a_clr = 1'b0;
    a_vin = 1'b0;
    chk("flush_valid", 128'(a_vout), 128'(0));
    chk("flush_ready", 128'(a_rout), 128'(1));
    chk("flush_data", a_dout, {4{INIT_A}});
    a_rdy = 1'b1;
    tick;
    chk("flush_no55", 128'(a_vout), 128'(0));

    fill_a(32'h30);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", 128'(a_vout), 128'(0));
    chk("arst_ready", 128'(a_rout), 128'(1));
    chk("arst_data", a_dout, {4{INIT_A}});
    #1;
    rstn  = 1'b1;
    a_rdy = 1'b1;
    a_vin = 1'b1;
    a_din = 128'(32'hA0);
    tick;
    chk("post_a0", a_dout, 128'(32'hA0));
    a_din = 128'(32'hA1);
    tick;
    chk("post_a1", a_dout, 128'(32'hA1));
    chk("post_valid", 128'(a_vout), 128'(1));
    a_vin = 1'b0;
    tick;
    chk("post_empty", 128'(a_vout), 128'(0));

    q.delete();
    for (int c = 0; c < 10000; c++) begin
      b_vin = ($urandom_range(0, 3) != 0);
      b_rdy = ($urandom_range(0, 3) != 0);
      b_clr = ($urandom_range(0, 63) == 0);
      b_din = {$urandom, $urandom};
      in_f  = b_vin && (q.size() < 2);
      out_f = (q.size() > 0) && b_rdy;
      stall = (q.size() > 0) && !b_rdy && !b_clr;
      last  = (q.size() > 0) ? q[0] : 64'h0;
      tick;
      if (b_clr) begin
        q.delete();
      end else begin
        if (out_f) void'(q.pop_front());
        if (in_f) q.push_back(b_din);
      end
      chk("rnd_valid", 128'(b_vout), 128'(q.size() > 0));
      chk("rnd_ready", 128'(b_rout), 128'(q.size() < 2));
      if (q.size() > 0) chk("rnd_data", 128'(b_dout), 128'(q[0]));
      if (stall) chk("rnd_stable", 128'(b_dout), 128'(last));
    end
    b_vin = 1'b0;
    b_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
